// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - coin codes, unit values and payout FSM states for the change dispenser
package vending_pkg;

  localparam int Q_UNITS = 5;
  localparam int D_UNITS = 2;
  localparam int N_UNITS = 1;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_N    = 2'b01,
    COIN_D    = 2'b10,
    COIN_Q    = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_OFFER,
    ST_FINISH
  } state_e;

  function automatic int unsigned coin_value(coin_e c);
    case (c)
      COIN_Q:  return Q_UNITS;
      COIN_D:  return D_UNITS;
      COIN_N:  return N_UNITS;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// rtl/change_coin_select.sv - greedy pick of the largest stocked coin that fits the remaining credit
module change_coin_select #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_remaining,
  input  logic             i_quarter_empty,
  input  logic             i_dime_empty,
  input  logic             i_nickel_empty,
  output logic [1:0]       o_coin,
  output logic [WIDTH-1:0] o_value
);
  import vending_pkg::*;

  coin_e w_pick;

  // Requiring value <= remaining here is what keeps the payout subtraction from underflowing.
  always_comb begin
    w_pick = COIN_NONE;
    if (!i_quarter_empty && i_remaining >= WIDTH'(Q_UNITS))
      w_pick = COIN_Q;
    else if (!i_dime_empty && i_remaining >= WIDTH'(D_UNITS))
      w_pick = COIN_D;
    else if (!i_nickel_empty && i_remaining >= WIDTH'(N_UNITS))
      w_pick = COIN_N;
  end

  assign o_coin  = w_pick;
  assign o_value = WIDTH'(coin_value(w_pick));

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change one coin at a time over a valid/ack handshake
module change_dispenser #(
  parameter int WIDTH       = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_amount,
  input  logic             i_quarter_empty,
  input  logic             i_dime_empty,
  input  logic             i_nickel_empty,
  input  logic             i_coin_ack,
  output logic             o_coin_valid,
  output logic [1:0]       o_coin_type,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fault,
  output logic [WIDTH-1:0] o_remaining
);
  import vending_pkg::*;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_coin_value;
  logic [1:0]       r_coin_type;
  logic [TW-1:0]    r_timer;
  logic             r_coin_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;

  logic [1:0]       w_coin;
  logic [WIDTH-1:0] w_value;

  change_coin_select #(.WIDTH(WIDTH)) u_select (
    .i_remaining    (r_remaining),
    .i_quarter_empty(i_quarter_empty),
    .i_dime_empty   (i_dime_empty),
    .i_nickel_empty (i_nickel_empty),
    .o_coin         (w_coin),
    .o_value        (w_value)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_coin_value <= '0;
      r_coin_type  <= COIN_NONE;
      r_timer      <= '0;
      r_coin_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_remaining <= i_amount;
            r_fault     <= 1'b0;
            if (i_amount == '0) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SELECT;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SELECT: begin
          r_timer <= '0;
          if (r_remaining == '0 || w_coin == COIN_NONE) begin
            r_fault     <= (r_remaining != '0);
            r_state     <= ST_FINISH;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_coin_type <= COIN_NONE;
          end else begin
            r_coin_type  <= w_coin;
            r_coin_value <= w_value;
            r_coin_valid <= 1'b1;
            r_state      <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // An ack on the same edge the timeout expires still counts as delivered.
          if (i_coin_ack) begin
            r_remaining  <= r_remaining - r_coin_value;
            r_coin_valid <= 1'b0;
            r_state      <= ST_SELECT;
          end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
            r_fault      <= 1'b1;
            r_coin_valid <= 1'b0;
            r_state      <= ST_FINISH;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_coin_type  <= COIN_NONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_coin_valid = r_coin_valid;
  assign o_coin_type  = r_coin_type;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_remaining  = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench: expected coins and done records queued, monitor pops
module tb_change_dispenser;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_load;
  logic [4:0] i_amount;
  logic       i_quarter_empty;
  logic       i_dime_empty;
  logic       i_nickel_empty;
  logic       i_coin_ack;
  logic       o_coin_valid;
  logic [1:0] o_coin_type;
  logic       o_busy;
  logic       o_done;
  logic       o_fault;
  logic [4:0] o_remaining;

  change_dispenser #(.WIDTH(5), .ACK_TIMEOUT(255)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_load         (i_load),
    .i_amount       (i_amount),
    .i_quarter_empty(i_quarter_empty),
    .i_dime_empty   (i_dime_empty),
    .i_nickel_empty (i_nickel_empty),
    .i_coin_ack     (i_coin_ack),
    .o_coin_valid   (o_coin_valid),
    .o_coin_type    (o_coin_type),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_fault        (o_fault),
    .o_remaining    (o_remaining)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit is_done;
    int coin;
    int fault;
    int rem;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_cycles = 0;
  bit   ack_en = 1'b0;
  int   lat_busy, lat_done, lat_valid, lat_rem, lat_valid2, lat_type;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_coin(input int c);
    exp_t e;
    e.is_done = 1'b0; e.coin = c; e.fault = 0; e.rem = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input int f, input int r);
    exp_t e;
    e.is_done = 1'b1; e.coin = 0; e.fault = f; e.rem = r;
    sb.push_back(e);
  endtask

  // Ejector model: acks one cycle after it sees a coin offered.
  initial begin
    i_coin_ack = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_coin_ack = ack_en && o_coin_valid;
    end
  end

  // Monitor: an accepted coin or a done pulse pops the next expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        if (o_coin_valid) valid_cycles++;
        if (o_coin_valid && i_coin_ack) begin
          if (sb.size() == 0) chk("unexpected_coin", int'(o_coin_type), -1);
          else begin
            e = sb.pop_front();
            chk("coin_type", int'(o_coin_type), e.is_done ? -1 : e.coin);
          end
        end
        if (o_done) begin
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("done_order", int'(e.is_done), 1);
            chk("done_fault", int'(o_fault), e.fault);
            chk("done_remaining", int'(o_remaining), e.rem);
            chk("done_busy_type", int'({o_busy, o_coin_type}), 0);
          end
        end
      end
    end
  end

  task automatic payout(input int amt, input bit qe, input bit de, input bit ne, input bit ack);
    i_quarter_empty = qe;
    i_dime_empty    = de;
    i_nickel_empty  = ne;
    ack_en          = ack;
    valid_cycles    = 0;
    @(negedge i_clk);
    i_amount = 5'(amt);
    i_load   = 1'b1;
    @(negedge i_clk);
    i_load    = 1'b0;
    lat_busy  = int'(o_busy);
    lat_done  = int'(o_done);
    lat_valid = int'(o_coin_valid);
    lat_rem   = int'(o_remaining);
    @(negedge i_clk);
    lat_valid2 = int'(o_coin_valid);
    lat_type   = int'(o_coin_type);
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while (sb.size() != 0 && c < 600) begin
      @(negedge i_clk);
      c++;
    end
    chk({nm, "_drain_left"}, sb.size(), 0);
    if (sb.size() != 0) begin
      sb.delete();
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
    end
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    int c;
    i_reset = 1'b1; i_load = 1'b0; i_amount = '0;
    i_quarter_empty = 1'b0; i_dime_empty = 1'b0; i_nickel_empty = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", int'({o_coin_valid, o_coin_type, o_busy, o_done, o_fault, o_remaining}), 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // 8 units, all stocked: Q, D, N
    push_coin(3); push_coin(2); push_coin(1); push_done(0, 0);
    payout(8, 0, 0, 0, 1);
    chk("t8_busy_k1", lat_busy, 1);
    chk("t8_valid_k1", lat_valid, 0);
    chk("t8_rem_k1", lat_rem, 8);
    chk("t8_valid_k2", lat_valid2, 1);
    chk("t8_type_k2", lat_type, 3);
    wait_drain("t8");

    // zero amount: done right after load, no coin
    push_done(0, 0);
    payout(0, 0, 0, 0, 1);
    chk("t0_done_k1", lat_done, 1);
    chk("t0_busy_k1", lat_busy, 0);
    chk("t0_valid_k2", lat_valid2, 0);
    wait_drain("t0");
    chk("t0_no_valid", valid_cycles, 0);

    // no quarters, 7 units: D, D, D, N
    push_coin(2); push_coin(2); push_coin(2); push_coin(1); push_done(0, 0);
    payout(7, 1, 0, 0, 1);
    wait_drain("t7");

    // no quarters or nickels, 3 units: D then stuck with 1
    push_coin(2); push_done(1, 1);
    payout(3, 1, 0, 1, 1);
    wait_drain("t3");
    chk("t3_fault_hold", int'(o_fault), 1);
    chk("t3_rem_hold", int'(o_remaining), 1);

    // only nickels missing, 1 unit: fault with no coin
    push_done(1, 1);
    payout(1, 0, 0, 1, 1);
    wait_drain("t1");
    chk("t1_no_valid", valid_cycles, 0);

    // 31 units: six quarters and a nickel; also clears the previous fault
    for (int i = 0; i < 6; i++) push_coin(3);
    push_coin(1); push_done(0, 0);
    payout(31, 0, 0, 0, 1);
    wait_drain("t31");

    // ejector never acks: timeout
    push_done(1, 5);
    payout(5, 0, 0, 0, 0);
    chk("tto_type", lat_type, 3);
    wait_drain("tto");
    chk("tto_valid_cycles", valid_cycles, 255);

    // load while busy is ignored
    push_coin(3); push_coin(1); push_done(0, 0);
    payout(6, 0, 0, 0, 0);
    i_amount = 5'd31;
    i_load   = 1'b1;
    repeat (4) @(negedge i_clk);
    i_load = 1'b0;
    chk("busy_load_rem", int'(o_remaining), 6);
    chk("busy_load_offer", int'({o_busy, o_coin_valid, o_coin_type}), 15);
    ack_en = 1'b1;
    wait_drain("tbusy");

    // reset while a coin is offered
    payout(5, 0, 0, 0, 0);
    c = 0;
    while (!o_coin_valid && c < 10) begin
      @(negedge i_clk);
      c++;
    end
    chk("rst_offer_seen", int'(o_coin_valid), 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rst_mid_outputs", int'({o_coin_valid, o_coin_type, o_busy, o_done, o_fault, o_remaining}), 0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // normal payout after the abort
    push_coin(3); push_coin(2); push_done(0, 0);
    payout(7, 0, 0, 0, 1);
    wait_drain("tpost");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
